// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register and a ready/ack data bus.
// Define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles without ack.
module mem_wb_stage #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] EX_MEM_Aluresult,
  input  logic [DATA_W-1:0] Ex_mem_writedata_Rs2,
  input  logic [4:0]        Rd_EX_MEM,
  input  logic              EX_MEMmemtoreg,
  input  logic              EX_MEMmemwrite,
  input  logic              EX_MEMregwrite,
  input  logic              EX_MEMmemread,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] MEM_WB_wbdata,
  output logic [4:0]        Rd_MEM_WB,
  output logic              MEM_WBregwrite,
  output logic              mem_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;

  logic access, ack_done, tmo_hit;
  logic [DATA_W-1:0] wb_sel;

  assign access   = EX_MEMmemread | EX_MEMmemwrite;
  assign ack_done = (state == S_WAIT) && mem_ack;
  // A store that also has memread set never returns load data.
  assign wb_sel   = (EX_MEMmemtoreg && !EX_MEMmemwrite) ? mem_rdata : EX_MEM_Aluresult;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  assign tmo_hit = (state == S_WAIT) && !mem_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign stall = access & ~(ack_done | tmo_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      MEM_WB_wbdata  <= '0;
      Rd_MEM_WB      <= '0;
      MEM_WBregwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt        <= '0;
      mem_err        <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      mem_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (access) begin
            state          <= S_WAIT;
            mem_req        <= 1'b1;
            mem_we         <= EX_MEMmemwrite;
            mem_addr       <= EX_MEM_Aluresult[ADDR_W-1:0];
            mem_wdata      <= Ex_mem_writedata_Rs2;
            MEM_WB_wbdata  <= '0;
            Rd_MEM_WB      <= '0;
            MEM_WBregwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
          end else begin
            MEM_WB_wbdata  <= EX_MEM_Aluresult;
            Rd_MEM_WB      <= Rd_EX_MEM;
            MEM_WBregwrite <= EX_MEMregwrite;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            state          <= S_IDLE;
            mem_req        <= 1'b0;
            MEM_WB_wbdata  <= wb_sel;
            Rd_MEM_WB      <= Rd_EX_MEM;
            MEM_WBregwrite <= EX_MEMregwrite;
          end else begin
            MEM_WB_wbdata  <= '0;
            Rd_MEM_WB      <= '0;
            MEM_WBregwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            if (tmo_hit) begin
              state   <= S_IDLE;
              mem_req <= 1'b0;
              mem_err <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register. It sits directly downstream of the EX/MEM register and consumes its outputs: ALU result, store data, Rd and control bits. It drives a ready/ack data-memory bus and stalls upstream until each load or store completes. It then presents write-back data, Rd and regwrite to the register file and forwarding logic.

Parameters:
DATA_W, 32, data/ALU width
ADDR_W, 32, memory address width (low ADDR_W bits of ALU result)
TIMEOUT_CYCLES, 16, WAIT cycles before abort (only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
EX_MEM_Aluresult  in  DATA_W  ALU result / memory address
Ex_mem_writedata_Rs2  in  DATA_W  store data
Rd_EX_MEM  in  5  destination register
EX_MEMmemtoreg  in  1  write-back select: 1 = load data, 0 = ALU
EX_MEMmemwrite  in  1  store
EX_MEMregwrite  in  1  register write enable
EX_MEMmemread  in  1  load
mem_req  out  1  bus request, registered
mem_we  out  1  1 = write, registered
mem_addr  out  ADDR_W  bus address, registered
mem_wdata  out  DATA_W  bus write data, registered
mem_rdata  in  DATA_W  bus read data, valid with mem_ack
mem_ack  in  1  bus completion, single-cycle pulse
stall  out  1  combinational; upstream (IF/ID/EX, EX_MEM) holds while 1
MEM_WB_wbdata  out  DATA_W  write-back data
Rd_MEM_WB  out  5  write-back register
MEM_WBregwrite  out  1  write-back enable
mem_err  out  1  abort flag (MEM_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (async, immediate): all outputs 0; state = IDLE; timeout counter = 0.
- access = EX_MEMmemread | EX_MEMmemwrite. If both are set, memwrite wins and the read is ignored.
- stall = access & !(state == WAIT & mem_ack).
- FSM states: IDLE, WAIT.
- IDLE, access = 0:
  - Edge loads MEM/WB: wbdata = Aluresult, Rd = Rd_EX_MEM, regwrite = EX_MEMregwrite.
  - Latency is 1 cycle.
- IDLE, access = 1:
  - Edge -> WAIT; mem_req = 1; mem_we = memwrite; mem_addr = Aluresult[ADDR_W-1:0]; mem_wdata = Rs2 data.
  - MEM/WB gets a bubble (regwrite = 0, Rd = 0, wbdata = 0).
- WAIT, mem_ack = 0:
  - Hold bus outputs and state.
  - MEM/WB bubble every edge.
- WAIT, mem_ack = 1:
  - stall drops the same cycle.
  - Edge -> IDLE; mem_req = 0; MEM/WB loads wbdata = (memtoreg & !memwrite) ? mem_rdata : Aluresult, plus Rd and regwrite.
- Minimum memory-op latency: 2 cycles (ack on first WAIT cycle).
- Back-to-back memory ops: each passes through IDLE for one cycle. No bus request overlap.
- mem_ack in IDLE is ignored.
- Inputs are sampled live every cycle. Upstream is responsible for holding them stable while stall = 1.
- Reset during WAIT: mem_req drops asynchronously; the pending access is discarded and no MEM/WB write occurs.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on IDLE->WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: edge -> IDLE, mem_req = 0, MEM/WB bubble, mem_err = 1 for exactly one cycle, and stall drops on that timeout cycle.
  - An ack on the same cycle as the timeout wins; normal completion, no mem_err.
- Undefined: no counter; WAIT persists until mem_ack; mem_err constant 0.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; release -> IDLE, stall = 0.
- ALU op: Aluresult = 0x0000_1234, Rd = 5, regwrite = 1, no mem -> next edge wbdata = 0x1234, Rd_MEM_WB = 5, regwrite = 1; stall never 1.
- Load, 3-cycle ack delay: addr 0x100, mem_rdata = 0xDEAD_BEEF -> mem_req high 3 cycles, stall high 3 cycles (low on the ack cycle), then wbdata = 0xDEADBEEF, Rd correct; regwrite = 0 during bubbles.
- Store then load back-to-back: store 0xA5A5_A5A5 to 0x40 (ack at once), then load 0x40 -> mem_we 1 then 0, one IDLE gap between requests, store regwrite = 0, load wbdata = returned data.
- memread = memwrite = 1 -> treated as store: mem_we = 1; wbdata = Aluresult, not rdata.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> after 4 WAIT cycles mem_req = 0, mem_err pulses 1 cycle, stall releases, no regwrite. Repeat with ack on cycle 4 -> normal load, mem_err = 0.
